// File: rtl/motion_pkg.sv
// Shared types and constants for the motion sequencer slice.
package motion_pkg;

    localparam int unsigned CMD_W     = 4;
    localparam int unsigned DUR_W     = 8;
    localparam int unsigned ENTRY_W   = CMD_W + DUR_W;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned N_ENTRIES = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    // Wheel codes, bit order {left_fwd, left_rev, right_fwd, right_rev}
    localparam logic [CMD_W-1:0] WC_STOP = 4'b0000;
    localparam logic [CMD_W-1:0] WC_FWD  = 4'b1010;
    localparam logic [CMD_W-1:0] WC_REV  = 4'b0101;
    localparam logic [CMD_W-1:0] WC_R1X  = 4'b1000;
    localparam logic [CMD_W-1:0] WC_L1X  = 4'b0010;
    localparam logic [CMD_W-1:0] WC_R2X  = 4'b1001;
    localparam logic [CMD_W-1:0] WC_L2X  = 4'b0110;

    // One program entry: wheel code held for dur ticks; dur == 0 ends the program
    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [DUR_W-1:0] dur;
    } prog_entry_t;

    // A wheel asked to go forward and reverse at once is stopped; the other wheel is untouched
    function automatic logic [CMD_W-1:0] sanitize(input logic [CMD_W-1:0] code);
        logic [1:0] left;
        logic [1:0] right;
        left  = code[3:2];
        right = code[1:0];
        if (left == 2'b11) begin
            left = 2'b00;
        end
        if (right == 2'b11) begin
            right = 2'b00;
        end
        return {left, right};
    endfunction

endpackage

// File: rtl/motion_sequencer_if.sv
// Control, programming and wheel-request signals of the motion sequencer.
interface motion_sequencer_if;
    import motion_pkg::*;

    logic             manual_en;
    logic [CMD_W-1:0] manual_cmd;
    logic             prog_we;
    logic [IDX_W-1:0] prog_addr;
    logic [ENTRY_W-1:0] prog_data;
    logic             start;
    logic             abort;
    logic             loop_en;

    logic             left_fwd;
    logic             left_rev;
    logic             right_fwd;
    logic             right_rev;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] step_idx;
    logic             owner;

    modport master (
        output manual_en, manual_cmd, prog_we, prog_addr, prog_data,
               start, abort, loop_en,
        input  left_fwd, left_rev, right_fwd, right_rev,
               busy, done, step_idx, owner
    );

    modport slave (
        input  manual_en, manual_cmd, prog_we, prog_addr, prog_data,
               start, abort, loop_en,
        output left_fwd, left_rev, right_fwd, right_rev,
               busy, done, step_idx, owner
    );

endinterface

// File: rtl/tick_gen.sv
// Free-running clock-enable generator: one-cycle tick every TICK_MAX+1 clocks.
module tick_gen #(
    parameter bit simulate = 1'b0
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned TICK_MAX = simulate ? 5 : 19_999_999;
    localparam int unsigned CNT_W    = $clog2(TICK_MAX + 1);

    logic [CNT_W-1:0] cnt_q;

    // Counter wraps at TICK_MAX; tick is registered so it is high exactly while cnt_q == TICK_MAX
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= (cnt_q == CNT_W'(TICK_MAX - 1));
            if (cnt_q == CNT_W'(TICK_MAX)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/motion_sequencer.sv
// Arbitrates manual switches against an 8-entry programmed wheel sequence.
module motion_sequencer
    import motion_pkg::*;
#(
    parameter bit simulate = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    motion_sequencer_if.slave bus
);

    logic             tick;
    prog_entry_t      table_q [N_ENTRIES];
    prog_entry_t      cur_entry_c;
    state_t           state_q;
    logic [IDX_W-1:0] step_idx_q;
    logic [DUR_W-1:0] remain_q;
    logic [CMD_W-1:0] cmd_q;
    logic [CMD_W-1:0] wheel_q;
    logic             busy_q;
    logic             done_q;
    logic             owner_q;

    tick_gen #(
        .simulate (simulate)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Program table: writable at any time and deliberately not reset so a program survives reset
    always_ff @(posedge clk) begin
        if (bus.prog_we) begin
            table_q[bus.prog_addr] <= prog_entry_t'(bus.prog_data);
        end
    end

    assign cur_entry_c = table_q[step_idx_q];

    // Sequencer FSM and registered output mux; outputs reflect the state one cycle earlier
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_idx_q <= '0;
            remain_q   <= '0;
            cmd_q      <= WC_STOP;
            wheel_q    <= WC_STOP;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            owner_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (bus.manual_en) begin
                wheel_q <= sanitize(bus.manual_cmd);
                owner_q <= 1'b0;
            end else if (state_q == ST_RUN) begin
                wheel_q <= cmd_q;
                owner_q <= 1'b1;
            end else begin
                wheel_q <= WC_STOP;
                owner_q <= 1'b0;
            end

            if (bus.abort) begin
                state_q    <= ST_IDLE;
                busy_q     <= 1'b0;
                step_idx_q <= '0;
                remain_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            state_q    <= ST_LOAD;
                            busy_q     <= 1'b1;
                            step_idx_q <= '0;
                        end
                    end
                    ST_LOAD: begin
                        if (cur_entry_c.dur != '0) begin
                            cmd_q    <= cur_entry_c.cmd;
                            remain_q <= cur_entry_c.dur;
                            state_q  <= ST_RUN;
                        end else if ((step_idx_q != '0) && bus.loop_en) begin
                            step_idx_q <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Manual takeover wins over a coincident tick; that tick is not counted
                        if (bus.manual_en) begin
                            state_q <= ST_PAUSE;
                        end else if (tick) begin
                            remain_q <= remain_q - DUR_W'(1);
                            if (remain_q == DUR_W'(1)) begin
                                if (step_idx_q != IDX_W'(N_ENTRIES - 1)) begin
                                    step_idx_q <= step_idx_q + IDX_W'(1);
                                    state_q    <= ST_LOAD;
                                end else if (bus.loop_en) begin
                                    step_idx_q <= '0;
                                    state_q    <= ST_LOAD;
                                end else begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (!bus.manual_en) begin
                            state_q <= ST_RUN;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign {bus.left_fwd, bus.left_rev, bus.right_fwd, bus.right_rev} = wheel_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.step_idx = step_idx_q;
    assign bus.owner    = owner_q;

endmodule
